assay_lane_scheduler: RTL and testbench



---
 rtl/assay_pkg.sv | 29 ++
 rtl/assay_lane_scheduler_rr_arbiter.sv | 36 +++
 rtl/assay_lane_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_assay_lane_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/assay_pkg.sv
// Package assay_pkg: shared types and helpers for the assay lane scheduler.
//   state_t     - sequencer FSM states (IDLE, FILL, MIX, DETECT, FLUSH)
//   *_CYCLES_DEF - default phase lengths in clock cycles
//   idx_w()     - width of an index into n items (minimum 1 bit)
//   max2()      - larger of two values, used to size the phase counter
package assay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        MIX,
        DETECT,
        FLUSH
    } state_t;

    localparam int unsigned FILL_CYCLES_DEF  = 16;
    localparam int unsigned MIX_CYCLES_DEF   = 64;
    localparam int unsigned DET_CYCLES_DEF   = 8;
    localparam int unsigned FLUSH_CYCLES_DEF = 16;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/assay_lane_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or
// after ptr, searching circularly. The parent registers the result.
//   req   [N]  - request vector
//   ptr   [W]  - lane with highest priority this round
//   grant [N]  - one-hot pick, zero when req is zero
//   idx   [W]  - binary index of the pick
module rr_arbiter
    import assay_pkg::*;
#(
    parameter int unsigned N = 12,
    parameter int unsigned W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);

    always_comb begin
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                idx      = W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/assay_lane_scheduler.sv
// assay_lane_scheduler: time-multiplexes one shared optical detector across
// N_LANES mixer/detector lanes. A round-robin arbiter picks a requesting lane,
// which is then driven through FILL, MIX, DETECT and FLUSH phases.
//   clk, rst     - clock, synchronous active-high reset
//   req          - per-lane level-sensitive assay request
//   grant        - one-hot lane being sequenced, zero when idle
//   valve_in     - inlet valve pair strobe (FILL)
//   pump_en      - mixer pump strobe (MIX)
//   det_en       - detector window strobe (DETECT)
//   valve_out    - outlet/flush valve strobe (FLUSH)
//   det_sample   - shared detector reading, captured on last DETECT cycle
//   abort        - (ASSAY_ABORT_EN only) skip straight to FLUSH, no result
//   res_valid    - one-cycle pulse on the first FLUSH cycle
//   res_lane     - lane index of the latest result
//   res_data     - latest captured sample
//   busy         - high in any non-IDLE state
// Optional feature macro: ASSAY_ABORT_EN
module assay_lane_scheduler
    import assay_pkg::*;
#(
    parameter int unsigned N_LANES      = 12,
    parameter int unsigned FILL_CYCLES  = FILL_CYCLES_DEF,
    parameter int unsigned MIX_CYCLES   = MIX_CYCLES_DEF,
    parameter int unsigned DET_CYCLES   = DET_CYCLES_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned SAMPLE_W     = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_LANES-1:0]          req,
    output logic [N_LANES-1:0]          grant,
    output logic [N_LANES-1:0]          valve_in,
    output logic [N_LANES-1:0]          pump_en,
    output logic [N_LANES-1:0]          det_en,
    output logic [N_LANES-1:0]          valve_out,
    input  logic [SAMPLE_W-1:0]         det_sample,
`ifdef ASSAY_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        res_valid,
    output logic [$clog2(N_LANES)-1:0]  res_lane,
    output logic [SAMPLE_W-1:0]         res_data,
    output logic                        busy
);

    localparam int unsigned LW      = idx_w(N_LANES);
    localparam int unsigned MAX_CYC = max2(max2(FILL_CYCLES, MIX_CYCLES),
                                           max2(DET_CYCLES, FLUSH_CYCLES));
    localparam int unsigned CNT_W   = idx_w(MAX_CYC);

    localparam logic [CNT_W-1:0] FILL_LD  = CNT_W'(FILL_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIX_LD   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] DET_LD   = CNT_W'(DET_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(FLUSH_CYCLES - 1);

    if (FILL_CYCLES == 0 || MIX_CYCLES == 0 || DET_CYCLES == 0 || FLUSH_CYCLES == 0) begin : g_bad_cycles
        $error("assay_lane_scheduler: every *_CYCLES parameter must be nonzero");
    end
    if (N_LANES < 2 || N_LANES > 32) begin : g_bad_lanes
        $error("assay_lane_scheduler: N_LANES must be in 2..32");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LW-1:0]      ptr;
    logic [LW-1:0]      gidx;
    logic [LW-1:0]      ptr_nx;
    logic [LW-1:0]      arb_ptr;
    logic [N_LANES-1:0] arb_grant;
    logic [LW-1:0]      arb_idx;

    assign ptr_nx  = (gidx == LW'(N_LANES - 1)) ? '0 : gidx + 1'b1;
    // During FLUSH the arbiter already sees the post-assay pointer, so a
    // back-to-back grant on the last FLUSH cycle honours round-robin order.
    assign arb_ptr = (state == FLUSH) ? ptr_nx : ptr;

    rr_arbiter #(
        .N (N_LANES),
        .W (LW)
    ) u_arb (
        .req   (req),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gidx      <= '0;
            grant     <= '0;
            valve_in  <= '0;
            pump_en   <= '0;
            det_en    <= '0;
            valve_out <= '0;
            res_valid <= 1'b0;
            res_lane  <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
        end else begin
            res_valid <= 1'b0;
`ifdef ASSAY_ABORT_EN
            if (abort && (state == FILL || state == MIX || state == DETECT)) begin
                state     <= FLUSH;
                cnt       <= FLUSH_LD;
                valve_in  <= '0;
                pump_en   <= '0;
                det_en    <= '0;
                valve_out <= grant;
            end else
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= FILL;
                        cnt      <= FILL_LD;
                        grant    <= arb_grant;
                        gidx     <= arb_idx;
                        valve_in <= arb_grant;
                        busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (cnt == '0) begin
                        state    <= MIX;
                        cnt      <= MIX_LD;
                        valve_in <= '0;
                        pump_en  <= grant;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                MIX: begin
                    if (cnt == '0) begin
                        state   <= DETECT;
                        cnt     <= DET_LD;
                        pump_en <= '0;
                        det_en  <= grant;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DETECT: begin
                    if (cnt == '0) begin
                        state     <= FLUSH;
                        cnt       <= FLUSH_LD;
                        det_en    <= '0;
                        valve_out <= grant;
                        res_valid <= 1'b1;
                        res_lane  <= gidx;
                        res_data  <= det_sample;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        ptr       <= ptr_nx;
                        valve_out <= '0;
                        if (|req) begin
                            state    <= FILL;
                            cnt      <= FILL_LD;
                            grant    <= arb_grant;
                            gidx     <= arb_idx;
                            valve_in <= arb_grant;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_assay_lane_scheduler.sv
// Directed bench for assay_lane_scheduler with a result scoreboard.
module tb_assay_lane_scheduler;

    localparam int N  = 12;
    localparam int SW = 12;

    typedef logic [5*N+1:0] vec_t;
    typedef struct {
        logic [3:0]    lane;
        logic [SW-1:0] data;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N-1:0]  grant, valve_in, pump_en, det_en, valve_out;
    logic [SW-1:0] det_sample;
    logic          res_valid;
    logic [3:0]    res_lane;
    logic [SW-1:0] res_data;
    logic          busy;
`ifdef ASSAY_ABORT_EN
    logic          abort;
`endif

    int checks   = 0;
    int failures = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    assay_lane_scheduler #(
        .N_LANES  (N),
        .SAMPLE_W (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .grant      (grant),
        .valve_in   (valve_in),
        .pump_en    (pump_en),
        .det_en     (det_en),
        .valve_out  (valve_out),
        .det_sample (det_sample),
`ifdef ASSAY_ABORT_EN
        .abort      (abort),
`endif
        .res_valid  (res_valid),
        .res_lane   (res_lane),
        .res_data   (res_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t observed();
        return {grant, valve_in, pump_en, det_en, valve_out, busy, res_valid};
    endfunction

    task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called on the first FILL cycle of an assay of 'lane'. Checks every cycle
    // against a phase model. req switches to req_mid in MIX and to req_end on
    // the last FLUSH cycle. abort_c >= 0 aborts in that cycle; stop_c ends the
    // walk early (leaves time positioned at cycle stop_c).
    task automatic run_assay(input int lane, input logic [N-1:0] req_mid,
                             input logic [N-1:0] req_end, input int abort_c,
                             input int stop_c);
        logic [N-1:0] oh;
        int           lim;
        oh  = N'(1) << lane;
        lim = (abort_c >= 0) ? abort_c + 17 : 104;
        if (stop_c < lim) lim = stop_c;
        for (int c = 0; c < lim; c++) begin
            logic         ab;
            logic [N-1:0] e_vin, e_pump, e_det, e_vout;
            logic         e_rv;
            res_t         r;
            ab     = (abort_c >= 0) && (c > abort_c);
            e_vin  = (!ab && c < 16) ? oh : '0;
            e_pump = (!ab && c >= 16 && c < 80) ? oh : '0;
            e_det  = (!ab && c >= 80 && c < 88) ? oh : '0;
            e_vout = (ab || c >= 88) ? oh : '0;
            e_rv   = (abort_c < 0) && (c == 88);
            det_sample = SW'($urandom);
            if (c == 87 && abort_c < 0) begin
                r.lane = 4'(lane);
                r.data = det_sample;
                sb.push_back(r);
            end
            chk_vec($sformatf("lane%0d_c%0d", lane, c), observed(),
                    {oh, e_vin, e_pump, e_det, e_vout, 1'b1, e_rv});
            if (e_rv) begin
                if (sb.size() == 0) begin
                    chk_val("sb_underflow", 1, 0);
                end else begin
                    r = sb.pop_front();
                    chk_val($sformatf("res_lane_l%0d", lane), int'(res_lane), int'(r.lane));
                    chk_val($sformatf("res_data_l%0d", lane), int'(res_data), int'(r.data));
                end
            end
            if (c == 20) req = req_mid;
            if (c == lim - 1 && lim == ((abort_c >= 0) ? abort_c + 17 : 104)) req = req_end;
`ifdef ASSAY_ABORT_EN
            abort = (c == abort_c);
`endif
            tick();
        end
`ifdef ASSAY_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        rst        = 1'b1;
        req        = '0;
        det_sample = '0;
`ifdef ASSAY_ABORT_EN
        abort      = 1'b0;
`endif
        repeat (3) tick();
        chk_vec("reset_vec", observed(), '0);
        chk_val("reset_res_lane", int'(res_lane), 0);
        chk_val("reset_res_data", int'(res_data), 0);
        rst = 1'b0;
        tick();
        chk_vec("idle_no_req", observed(), '0);

        // Single request on lane 2, back to idle afterwards.
        req = 12'h004;
        tick();
        run_assay(2, 12'h004, '0, -1, 104);
        chk_vec("idle_after_single", observed(), '0);

        // Fairness from pointer 0 with all lanes requesting, no idle gaps.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '1;
        tick();
        for (int k = 0; k < 13; k++)
            run_assay(k % N, '1, (k == 12) ? '0 : '1, -1, 104);
        chk_vec("idle_after_fair", observed(), '0);

        // Lane 10 moves the pointer to 11; then 11 and 0 request together.
        req = 12'h400;
        tick();
        run_assay(10, 12'h400, 12'h801, -1, 104);
        run_assay(11, 12'h801, 12'h801, -1, 104);
        run_assay(0, 12'h801, '0, -1, 104);
        chk_vec("idle_after_wrap", observed(), '0);

        // Request on lane 5 drops during MIX; assay still completes.
        req = 12'h020;
        tick();
        run_assay(5, '0, '0, -1, 104);
        chk_vec("idle_after_drop", observed(), '0);

        // Reset during DETECT on lane 7, then lanes 3 and 7 request: pointer
        // back at 0 picks lane 3.
        req = 12'h080;
        tick();
        run_assay(7, 12'h080, 12'h080, -1, 83);
        rst = 1'b1;
        tick();
        chk_vec("rst_mid_detect", observed(), '0);
        rst = 1'b0;
        req = 12'h088;
        tick();
        run_assay(3, 12'h088, '0, -1, 104);
        chk_vec("idle_after_rst_test", observed(), '0);

`ifdef ASSAY_ABORT_EN
        // Abort in MIX cycle 10: straight to a full FLUSH, no result.
        req = 12'h001;
        tick();
        run_assay(0, 12'h001, '0, 26, 104);
        chk_vec("idle_after_abort", observed(), '0);
`endif

        chk_val("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
